// File: rtl/ram_port_arbiter.sv
// Shares one synchronous block-RAM port between instruction fetch and the data path.
// Build option: define ARB_FIXED_PRIO_EN for fixed data-over-fetch priority instead of round-robin.
module ram_port_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    localparam logic [2:0] LAT_INIT = 3'(RD_LAT);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t            state_r, state_s;
    logic [2:0]        cnt_r, cnt_s;
    logic              owner_data_r, owner_data_s;
    logic              if_gnt_r, if_gnt_s;
    logic              d_gnt_r, d_gnt_s;
    logic              if_rvalid_r, if_rvalid_s;
    logic              d_rvalid_r, d_rvalid_s;
    logic [DATA_W-1:0] if_rdata_r, if_rdata_s;
    logic [DATA_W-1:0] d_rdata_r, d_rdata_s;
    logic [ADDR_W-1:0] ram_addr_r, ram_addr_s;
    logic              ram_we_r, ram_we_s;
    logic [DATA_W-1:0] ram_wdata_r, ram_wdata_s;
    logic              busy_r, busy_s;
    logic              any_req_s;
    logic              pick_data_s;

    assign any_req_s = if_req | d_req;

`ifdef ARB_FIXED_PRIO_EN
    // Data side always takes the port when it asks
    always_comb begin
        pick_data_s = d_req;
    end
`else
    logic last_data_r;

    // On a conflict the side that did not win last time gets the port
    always_comb begin
        if (if_req && d_req) begin
            pick_data_s = ~last_data_r;
        end else begin
            pick_data_s = d_req;
        end
    end

    // Last winner starts as data so the very first tie goes to fetch
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_data_r <= 1'b1;
        end else if ((state_r == ST_IDLE) && any_req_s) begin
            last_data_r <= pick_data_s;
        end else begin
            last_data_r <= last_data_r;
        end
    end
`endif

    // Next-state and next-output decode for the IDLE/ACCESS sequencer
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        owner_data_s = owner_data_r;
        if_gnt_s     = 1'b0;
        d_gnt_s      = 1'b0;
        if_rvalid_s  = 1'b0;
        d_rvalid_s   = 1'b0;
        if_rdata_s   = if_rdata_r;
        d_rdata_s    = d_rdata_r;
        ram_addr_s   = ram_addr_r;
        ram_we_s     = 1'b0;
        ram_wdata_s  = ram_wdata_r;
        busy_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_s      = ST_ACCESS;
                    cnt_s        = LAT_INIT;
                    owner_data_s = pick_data_s;
                    if (pick_data_s) begin
                        d_gnt_s     = 1'b1;
                        ram_addr_s  = d_addr;
                        ram_we_s    = d_we;
                        ram_wdata_s = d_wdata;
                    end else begin
                        if_gnt_s    = 1'b1;
                        ram_addr_s  = if_addr;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (ram_we_r) begin
                    state_s = ST_IDLE;
                end else if (cnt_r == 3'd0) begin
                    // RAM output is valid this cycle; hand it to the owner
                    state_s = ST_IDLE;
                    if (owner_data_r) begin
                        d_rvalid_s = 1'b1;
                        d_rdata_s  = ram_rdata;
                    end else begin
                        if_rvalid_s = 1'b1;
                        if_rdata_s  = ram_rdata;
                    end
                end else begin
                    cnt_s = cnt_r - 3'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        busy_s = (state_s == ST_ACCESS);
    end

    // State and registered outputs; reset aborts any access in flight
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 3'd0;
            owner_data_r <= 1'b0;
            if_gnt_r     <= 1'b0;
            d_gnt_r      <= 1'b0;
            if_rvalid_r  <= 1'b0;
            d_rvalid_r   <= 1'b0;
            if_rdata_r   <= {DATA_W{1'b0}};
            d_rdata_r    <= {DATA_W{1'b0}};
            ram_addr_r   <= {ADDR_W{1'b0}};
            ram_we_r     <= 1'b0;
            ram_wdata_r  <= {DATA_W{1'b0}};
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            owner_data_r <= owner_data_s;
            if_gnt_r     <= if_gnt_s;
            d_gnt_r      <= d_gnt_s;
            if_rvalid_r  <= if_rvalid_s;
            d_rvalid_r   <= d_rvalid_s;
            if_rdata_r   <= if_rdata_s;
            d_rdata_r    <= d_rdata_s;
            ram_addr_r   <= ram_addr_s;
            ram_we_r     <= ram_we_s;
            ram_wdata_r  <= ram_wdata_s;
            busy_r       <= busy_s;
        end
    end

    assign if_gnt    = if_gnt_r;
    assign d_gnt     = d_gnt_r;
    assign if_rvalid = if_rvalid_r;
    assign d_rvalid  = d_rvalid_r;
    assign if_rdata  = if_rdata_r;
    assign d_rdata   = d_rdata_r;
    assign ram_addr  = ram_addr_r;
    assign ram_we    = ram_we_r;
    assign ram_wdata = ram_wdata_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed scoreboard bench for ram_port_arbiter: instance A uses RD_LAT=1, instance B uses RD_LAT=3.
module tb_ram_port_arbiter;

    logic clock;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic        if_req_a, d_req_a, d_we_a;
    logic [15:0] if_addr_a, d_addr_a, d_wdata_a;
    logic        if_gnt_a, if_rvalid_a, d_gnt_a, d_rvalid_a, ram_we_a, busy_a;
    logic [15:0] if_rdata_a, d_rdata_a, ram_addr_a, ram_wdata_a, ram_rdata_a;

    logic        if_req_b, d_req_b, d_we_b;
    logic [15:0] if_addr_b, d_addr_b, d_wdata_b;
    logic        if_gnt_b, if_rvalid_b, d_gnt_b, d_rvalid_b, ram_we_b, busy_b;
    logic [15:0] if_rdata_b, d_rdata_b, ram_addr_b, ram_wdata_b;

    logic        pre_we;
    logic [15:0] pre_addr, pre_data;
    logic [15:0] mem_a [0:65535];
    logic [15:0] mem_b [0:65535];
    logic [15:0] pipe_b [0:2];

    logic [15:0] if_q [$];
    logic [15:0] d_q [$];
    logic [15:0] db_q [$];

    ram_port_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(1)) dut_a (
        .clock(clock), .reset(reset),
        .if_req(if_req_a), .if_addr(if_addr_a), .if_gnt(if_gnt_a),
        .if_rvalid(if_rvalid_a), .if_rdata(if_rdata_a),
        .d_req(d_req_a), .d_we(d_we_a), .d_addr(d_addr_a), .d_wdata(d_wdata_a),
        .d_gnt(d_gnt_a), .d_rvalid(d_rvalid_a), .d_rdata(d_rdata_a),
        .ram_addr(ram_addr_a), .ram_we(ram_we_a), .ram_wdata(ram_wdata_a),
        .ram_rdata(ram_rdata_a), .busy(busy_a)
    );

    ram_port_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(3)) dut_b (
        .clock(clock), .reset(reset),
        .if_req(if_req_b), .if_addr(if_addr_b), .if_gnt(if_gnt_b),
        .if_rvalid(if_rvalid_b), .if_rdata(if_rdata_b),
        .d_req(d_req_b), .d_we(d_we_b), .d_addr(d_addr_b), .d_wdata(d_wdata_b),
        .d_gnt(d_gnt_b), .d_rvalid(d_rvalid_b), .d_rdata(d_rdata_b),
        .ram_addr(ram_addr_b), .ram_we(ram_we_b), .ram_wdata(ram_wdata_b),
        .ram_rdata(pipe_b[2]), .busy(busy_b)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    // RAM models: A has one cycle of read latency, B three
    always @(posedge clock) begin
        if (pre_we) begin
            mem_a[pre_addr] <= pre_data;
            mem_b[pre_addr] <= pre_data;
        end else begin
            if (ram_we_a) mem_a[ram_addr_a] <= ram_wdata_a;
            if (ram_we_b) mem_b[ram_addr_b] <= ram_wdata_b;
        end
        ram_rdata_a <= mem_a[ram_addr_a];
        pipe_b[0]   <= mem_b[ram_addr_b];
        pipe_b[1]   <= pipe_b[0];
        pipe_b[2]   <= pipe_b[1];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // sel: 0 if_gnt_a, 1 d_gnt_a, 2 if_rvalid_a, 3 d_rvalid_a, 4 d_gnt_b, 5 d_rvalid_b
    task automatic wait_ev(input int sel, output int at);
        at = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if ((sel == 0 && if_gnt_a) || (sel == 1 && d_gnt_a) ||
                (sel == 2 && if_rvalid_a) || (sel == 3 && d_rvalid_a) ||
                (sel == 4 && d_gnt_b) || (sel == 5 && d_rvalid_b)) begin
                at = cyc;
                break;
            end
        end
        check($sformatf("wait_sel%0d", sel), 32'(at >= 0), 32'd1);
    endtask

    task automatic a_load(input bit is_data, input logic [15:0] addr, input logic [15:0] expv,
                          input string tag);
        int g, r;
        if (is_data) begin
            d_q.push_back(expv);
            d_we_a = 1'b0; d_addr_a = addr; d_req_a = 1'b1;
        end else begin
            if_q.push_back(expv);
            if_addr_a = addr; if_req_a = 1'b1;
        end
        wait_ev(is_data ? 1 : 0, g);
        if_req_a = 1'b0;
        d_req_a  = 1'b0;
        wait_ev(is_data ? 3 : 2, r);
        check({tag, "_lat"}, 32'(r - g), 32'd2);
        if (is_data) check({tag, "_data"}, 32'(d_rdata_a), 32'(d_q.pop_front()));
        else         check({tag, "_data"}, 32'(if_rdata_a), 32'(if_q.pop_front()));
    endtask

    initial begin
        int g, r, ng, wi, rv, ng2, last_g_if, last_g_d;
        bit both_gnt, both_rv, consec, prev_we, rv_seen, busy3, busy4;
        bit exp_who [4];
        bit gw [4];
        int gc [4];
        int wc [3];
        logic [15:0] wdat [3];
        logic [15:0] rvdata;

        reset = 1'b0;
        if_req_a = 1'b0; if_addr_a = 16'h0; d_req_a = 1'b0; d_we_a = 1'b0;
        d_addr_a = 16'h0; d_wdata_a = 16'h0;
        if_req_b = 1'b0; if_addr_b = 16'h0; d_req_b = 1'b0; d_we_b = 1'b0;
        d_addr_b = 16'h0; d_wdata_b = 16'h0;
        pre_we = 1'b1; pre_addr = 16'h0004; pre_data = 16'h5A13;
        @(negedge clock);
        pre_addr = 16'h00FF; pre_data = 16'hC3A5;
        @(negedge clock);
        pre_we = 1'b0;
        @(negedge clock);

        // Reset state
        check("rst_flags", 32'({if_gnt_a, d_gnt_a, if_rvalid_a, d_rvalid_a, ram_we_a, busy_a}), 32'd0);
        check("rst_addr_wdata", {ram_addr_a, ram_wdata_a}, 32'd0);
        check("rst_rdata", {if_rdata_a, d_rdata_a}, 32'd0);
        check("rst_busy_b", 32'(busy_b), 32'd0);
        reset = 1'b1;

        // Single fetch of address 4
        if_q.push_back(16'h5A13);
        if_addr_a = 16'h0004; if_req_a = 1'b1;
        wait_ev(0, g);
        check("f_addr", 32'(ram_addr_a), 32'h0004);
        check("f_we", 32'(ram_we_a), 32'd0);
        check("f_busy_g", 32'(busy_a), 32'd1);
        check("f_dgnt", 32'(d_gnt_a), 32'd0);
        if_req_a = 1'b0;
        @(negedge clock);
        check("f_gnt_pulse", 32'(if_gnt_a), 32'd0);
        check("f_busy_g1", 32'(busy_a), 32'd1);
        check("f_rv_early", 32'(if_rvalid_a), 32'd0);
        @(negedge clock);
        check("f_rvalid", 32'(if_rvalid_a), 32'd1);
        check("f_rdata", 32'(if_rdata_a), 32'(if_q.pop_front()));
        check("f_busy_g2", 32'(busy_a), 32'd0);
        @(negedge clock);
        check("f_rv_pulse", 32'(if_rvalid_a), 32'd0);
        check("f_rdata_hold", 32'(if_rdata_a), 32'h5A13);

        // Store then load back
        d_we_a = 1'b1; d_addr_a = 16'h0010; d_wdata_a = 16'hBEEF; d_req_a = 1'b1;
        wait_ev(1, g);
        check("st_we", 32'(ram_we_a), 32'd1);
        check("st_addr", 32'(ram_addr_a), 32'h0010);
        check("st_wdata", 32'(ram_wdata_a), 32'hBEEF);
        d_req_a = 1'b0;
        @(negedge clock);
        check("st_we_drop", 32'(ram_we_a), 32'd0);
        check("st_busy_done", 32'(busy_a), 32'd0);
        rv_seen = d_rvalid_a;
        @(negedge clock);
        rv_seen = rv_seen | d_rvalid_a;
        check("st_no_rvalid", 32'(rv_seen), 32'd0);
        a_load(1'b1, 16'h0010, 16'hBEEF, "ld_beef");

        // Conflict from reset: both loads held
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
`ifdef ARB_FIXED_PRIO_EN
        exp_who = '{1'b1, 1'b1, 1'b1, 1'b1};
`else
        exp_who = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
        for (int k = 0; k < 4; k++) begin
            if (exp_who[k]) d_q.push_back(16'hBEEF);
            else            if_q.push_back(16'h5A13);
        end
        if_addr_a = 16'h0004; if_req_a = 1'b1;
        d_we_a = 1'b0; d_addr_a = 16'h0010; d_req_a = 1'b1;
        ng = 0; last_g_if = -100; last_g_d = -100; both_gnt = 1'b0; both_rv = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (if_gnt_a && d_gnt_a) both_gnt = 1'b1;
            if (if_rvalid_a && d_rvalid_a) both_rv = 1'b1;
            if (if_gnt_a || d_gnt_a) begin
                if (ng < 4) begin
                    gw[ng] = d_gnt_a;
                    gc[ng] = cyc;
                end
                ng++;
                if (d_gnt_a) last_g_d = cyc;
                else         last_g_if = cyc;
                if (ng == 4) begin
                    if_req_a = 1'b0;
                    d_req_a  = 1'b0;
                end
            end
            if (if_rvalid_a) begin
                check("rr_if_lat", 32'(cyc - last_g_if), 32'd2);
                check("rr_if_expected", 32'(if_q.size() > 0), 32'd1);
                if (if_q.size() > 0) check("rr_if_data", 32'(if_rdata_a), 32'(if_q.pop_front()));
            end
            if (d_rvalid_a) begin
                check("rr_d_lat", 32'(cyc - last_g_d), 32'd2);
                check("rr_d_expected", 32'(d_q.size() > 0), 32'd1);
                if (d_q.size() > 0) check("rr_d_data", 32'(d_rdata_a), 32'(d_q.pop_front()));
            end
        end
        check("rr_grants", 32'(ng), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rr_who%0d", k), 32'(gw[k]), 32'(exp_who[k]));
            check($sformatf("rr_gap%0d", k), 32'(gc[k] - gc[0]), 32'(3 * k));
        end
        check("rr_one_gnt", 32'(both_gnt), 32'd0);
        check("rr_one_rvalid", 32'(both_rv), 32'd0);
        check("rr_queues_empty", 32'(if_q.size() + d_q.size()), 32'd0);

        // RD_LAT=3 load of 00FF with the request held for a second grant
        db_q.push_back(16'hC3A5);
        db_q.push_back(16'hC3A5);
        d_addr_b = 16'h00FF; d_we_b = 1'b0; d_req_b = 1'b1;
        wait_ev(4, g);
        rv = -1; ng2 = -1; busy3 = 1'b0; busy4 = 1'b1; rvdata = 16'h0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (cyc == g + 3) busy3 = busy_b;
            if (cyc == g + 4) busy4 = busy_b;
            if (d_rvalid_b && rv < 0) begin
                rv = cyc;
                rvdata = d_rdata_b;
            end
            if (d_gnt_b) begin
                ng2 = cyc;
                break;
            end
        end
        d_req_b = 1'b0;
        check("l3_rvalid_at", 32'(rv - g), 32'd4);
        check("l3_data", 32'(rvdata), 32'(db_q.pop_front()));
        check("l3_busy_g3", 32'(busy3), 32'd1);
        check("l3_busy_g4", 32'(busy4), 32'd0);
        check("l3_next_gnt", 32'(ng2 - g), 32'd5);
        wait_ev(5, r);
        check("l3_second_lat", 32'(r - ng2), 32'd4);
        check("l3_second_data", 32'(d_rdata_b), 32'(db_q.pop_front()));
        check("b_fetch_idle", {15'd0, if_gnt_b, if_rvalid_b, if_rdata_b}, 32'd0);

        // Reset in the middle of a fetch read, request kept pending
        if_q.push_back(16'h5A13);
        if_addr_a = 16'h0004; if_req_a = 1'b1;
        wait_ev(0, g);
        reset = 1'b0;
        #1;
        check("ra_busy", 32'(busy_a), 32'd0);
        check("ra_we", 32'(ram_we_a), 32'd0);
        check("ra_gnt", 32'(if_gnt_a), 32'd0);
        rv_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            rv_seen = rv_seen | if_rvalid_a | if_gnt_a;
        end
        check("ra_no_rvalid", 32'(rv_seen), 32'd0);
        reset = 1'b1;
        r = cyc;
        wait_ev(0, g);
        check("ra_regrant", 32'(g - r), 32'd1);
        if_req_a = 1'b0;
        wait_ev(2, r);
        check("ra_lat", 32'(r - g), 32'd2);
        check("ra_data", 32'(if_rdata_a), 32'(if_q.pop_front()));

        // Back-to-back stores from the data port
        wdat = '{16'h1111, 16'h2222, 16'h3333};
        d_we_a = 1'b1; d_addr_a = 16'h0020; d_wdata_a = wdat[0]; d_req_a = 1'b1;
        wi = 0; prev_we = 1'b0; consec = 1'b0; rv_seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            if (ram_we_a && prev_we) consec = 1'b1;
            prev_we = ram_we_a;
            if (d_rvalid_a) rv_seen = 1'b1;
            if (d_gnt_a && wi < 3) begin
                check($sformatf("bb_we%0d", wi), 32'(ram_we_a), 32'd1);
                check($sformatf("bb_addr%0d", wi), 32'(ram_addr_a), 32'(16'h0020 + 16'(wi)));
                check($sformatf("bb_wdata%0d", wi), 32'(ram_wdata_a), 32'(wdat[wi]));
                wc[wi] = cyc;
                wi++;
                if (wi < 3) begin
                    d_addr_a  = 16'h0020 + 16'(wi);
                    d_wdata_a = wdat[wi];
                end else begin
                    d_req_a = 1'b0;
                end
            end
        end
        check("bb_count", 32'(wi), 32'd3);
        check("bb_gap01", 32'(wc[1] - wc[0]), 32'd2);
        check("bb_gap12", 32'(wc[2] - wc[1]), 32'd2);
        check("bb_we_not_consec", 32'(consec), 32'd0);
        check("bb_no_rvalid", 32'(rv_seen), 32'd0);
        a_load(1'b1, 16'h0021, 16'h2222, "bb_readback");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
